// File: rtl/board_text_stream.sv
// Renders a ROWS x COLS game board as an ASCII frame on a byte-wide valid/ready stream.
// Each frame is a leading newline, then each row's cells separated by spaces and ended by a newline.
module board_text_stream #(
   parameter int          ROWS            = 3,
   parameter int          COLS            = 3,
   parameter int          CELL_W          = 2,
   parameter logic [7:0]  EMPTY_CHAR      = "_",
   parameter logic [7:0]  P1_CHAR         = "X",
   parameter logic [7:0]  P2_CHAR         = "O",
   parameter logic [7:0]  BAD_CHAR        = "?",
   parameter bit          PRINT_ON_CHANGE = 1'b0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [ROWS*COLS*CELL_W-1:0] board,
   input  logic                       start,
   output logic [7:0]                 char_data,
   output logic                       char_valid,
   input  logic                       char_ready,
   output logic                       busy,
   output logic                       frame_done,
   output logic [15:0]                frame_count
);

   localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [R_W-1:0] ROW_LAST = R_W'(ROWS - 1);
   localparam logic [C_W-1:0] COL_LAST = C_W'(COLS - 1);
   localparam logic [7:0] CH_NL = 8'h0A;
   localparam logic [7:0] CH_SP = 8'h20;

   typedef enum logic [2:0] {IDLE, LEAD, CELL, SEP, EOL, DONE} state_t;

   state_t                       state;
   logic [ROWS*COLS*CELL_W-1:0]  snapshot;
   logic [R_W-1:0]               row;
   logic [C_W-1:0]               col;
   logic [R_W-1:0]               row_next;
   logic [C_W-1:0]               col_next;
   logic                         accept;
   logic                         trigger;

   function automatic logic [7:0] map_code(input logic [CELL_W-1:0] code);
      if (code == CELL_W'(0))      return EMPTY_CHAR;
      else if (code == CELL_W'(1)) return P1_CHAR;
      else if (code == CELL_W'(2)) return P2_CHAR;
      else                         return BAD_CHAR;
   endfunction

   // Glyph table padded to a power-of-two grid so row/col index it at their natural width.
   logic [7:0] glyph [2**R_W][2**C_W];

   for (genvar gr = 0; gr < 2**R_W; gr++) begin : g_row
      for (genvar gc = 0; gc < 2**C_W; gc++) begin : g_col
         if (gr < ROWS && gc < COLS) begin : g_cell
            assign glyph[gr][gc] = map_code(snapshot[(gr*COLS+gc)*CELL_W +: CELL_W]);
         end else begin : g_pad
            assign glyph[gr][gc] = 8'h00;
         end
      end
   end

   assign accept   = char_valid & char_ready;
   assign row_next = row + 1'b1;
   assign col_next = col + 1'b1;
   assign trigger  = start || (PRINT_ON_CHANGE && (board != snapshot));

   // NOTE: every register here, outputs included, is written with <= so all of them
   // see the same pre-edge values; a blocking write would leak into later reads.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         // NOTE: the snapshot is reset too: change mode compares against it, so an
         // unreset snapshot would make the first frame after reset unpredictable.
         snapshot    <= '0;
         row         <= '0;
         col         <= '0;
         char_data   <= 8'h00;
         char_valid  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  snapshot   <= board;
                  row        <= '0;
                  col        <= '0;
                  state      <= LEAD;
                  char_data  <= CH_NL;
                  char_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            LEAD: begin
               if (accept) begin
                  state     <= CELL;
                  char_data <= glyph[R_W'(0)][C_W'(0)];
               end
            end
            CELL: begin
               if (accept) begin
                  if (col != COL_LAST) begin
                     state     <= SEP;
                     char_data <= CH_SP;
                  end else begin
                     state     <= EOL;
                     char_data <= CH_NL;
                  end
               end
            end
            SEP: begin
               if (accept) begin
                  col       <= col_next;
                  state     <= CELL;
                  char_data <= glyph[row][col_next];
               end
            end
            EOL: begin
               if (accept) begin
                  if (row != ROW_LAST) begin
                     row       <= row_next;
                     col       <= '0;
                     state     <= CELL;
                     char_data <= glyph[row_next][C_W'(0)];
                  end else begin
                     state       <= DONE;
                     char_data   <= 8'h00;
                     char_valid  <= 1'b0;
                     busy        <= 1'b0;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_text_stream.sv
// Self-checking bench for board_text_stream: three builds (3x3, 3x3 change mode, 2x4)
// compared against a string-level frame model with random boards and backpressure.
module tb_board_text_stream;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        char_ready;
   logic [1:0]  sel;

   logic [17:0] board_a, board_c;
   logic [15:0] board_b;
   logic        start_a, start_c, start_b;

   logic [7:0]  data_a, data_c, data_b;
   logic        valid_a, valid_c, valid_b;
   logic        busy_a, busy_c, busy_b;
   logic        done_a, done_c, done_b;
   logic [15:0] count_a, count_c, count_b;

   logic [7:0]  o_data;
   logic        o_valid, o_busy, o_done;
   logic [15:0] o_count;

   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          n_cmp, n_bad;

   always #5 clock = ~clock;

   assign start_a = start && (sel == 2'd0);
   assign start_c = start && (sel == 2'd1);
   assign start_b = start && (sel == 2'd2);

   board_text_stream u_a (
      .clock(clock), .reset_n(reset_n), .board(board_a), .start(start_a),
      .char_data(data_a), .char_valid(valid_a), .char_ready(char_ready),
      .busy(busy_a), .frame_done(done_a), .frame_count(count_a));

   board_text_stream #(.PRINT_ON_CHANGE(1'b1)) u_c (
      .clock(clock), .reset_n(reset_n), .board(board_c), .start(start_c),
      .char_data(data_c), .char_valid(valid_c), .char_ready(char_ready),
      .busy(busy_c), .frame_done(done_c), .frame_count(count_c));

   board_text_stream #(.ROWS(2), .COLS(4)) u_b (
      .clock(clock), .reset_n(reset_n), .board(board_b), .start(start_b),
      .char_data(data_b), .char_valid(valid_b), .char_ready(char_ready),
      .busy(busy_b), .frame_done(done_b), .frame_count(count_b));

   always_comb begin
      case (sel)
         2'd1:    begin o_data = data_c; o_valid = valid_c; o_busy = busy_c; o_done = done_c; o_count = count_c; end
         2'd2:    begin o_data = data_b; o_valid = valid_b; o_busy = busy_b; o_done = done_b; o_count = count_b; end
         default: begin o_data = data_a; o_valid = valid_a; o_busy = busy_a; o_done = done_a; o_count = count_a; end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame model: newline, then each row as cell glyphs joined by spaces, then newline.
   task automatic make_expected(input logic [17:0] b, input int rows, input int cols);
      logic [7:0] glyphs [4];
      int code;
      glyphs = '{"_", "X", "O", "?"};
      exp_q.delete();
      exp_q.push_back(8'h0A);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            code = int'((b >> (2 * (r * cols + c))) & 18'd3);
            exp_q.push_back(glyphs[code]);
            if (c < cols - 1) exp_q.push_back(8'h20);
         end
         exp_q.push_back(8'h0A);
      end
   endtask

   // Called at a negedge: the trigger is sampled at the next edge, LEAD is visible after it.
   task automatic trigger(input bit use_start);
      if (use_start) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("lead_valid", o_valid, 1);
      check("lead_data", o_data, 8'h0A);
      check("lead_busy", o_busy, 1);
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
   // act_kind at act_at accepted chars: 1 start pulse + board_a change, 2 board_c change, 3 reset.
   task automatic capture(input int ready_mode, input int act_at, input int act_kind,
                          output bit aborted);
      logic [7:0] prev_data;
      bit         prev_stall;
      bit         finished;
      bit         ready;
      int         exp_len;
      prev_stall = 1'b0;
      finished   = 1'b0;
      aborted    = 1'b0;
      prev_data  = 8'h00;
      exp_len    = exp_q.size();
      got_q.delete();
      for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
         start = 1'b0;
         if (prev_stall) begin
            check("hold_valid", o_valid, 1);
            check("hold_data", o_data, prev_data);
         end
         if (got_q.size() == exp_len) begin
            check("done_pulse", o_done, 1);
            check("done_busy", o_busy, 0);
            check("done_valid", o_valid, 0);
            if (ready_mode == 0) check("throughput_cycles", cyc, exp_len);
            finished = 1'b1;
         end else begin
            check("busy_in_frame", o_busy, 1);
            case (ready_mode)
               0:       ready = 1'b1;
               1:       ready = (cyc % 3) == 0;
               default: ready = 1'($urandom_range(0, 1));
            endcase
            char_ready = ready;
            if (o_valid && ready) begin
               got_q.push_back(o_data);
               if (got_q.size() == act_at) begin
                  case (act_kind)
                     1:       begin start = 1'b1; board_a = 18'($urandom); end
                     2:       board_c[1:0] = 2'd2;
                     3:       reset_n = 1'b0;
                     default: ;
                  endcase
               end
            end
            prev_stall = o_valid && !ready;
            prev_data  = o_data;
            @(negedge clock);
            if (!reset_n) begin
               check("rst_valid", o_valid, 0);
               check("rst_busy", o_busy, 0);
               check("rst_count", o_count, 0);
               check("rst_done", o_done, 0);
               aborted = 1'b1;
            end
         end
      end
      char_ready = 1'b1;
      if (!finished && !aborted) check("frame_timeout", 0, 1);
   endtask

   task automatic compare_frame();
      check("frame_len", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check($sformatf("char%0d", i), got_q[i], exp_q[i]);
   endtask

   task automatic compare_literal(input string s);
      if (got_q.size() == s.len())
         for (int i = 0; i < s.len(); i++) check($sformatf("lit%0d", i), got_q[i], s[i]);
      else
         check("lit_len", got_q.size(), s.len());
   endtask

   task automatic post_frame(input int exp_count);
      @(negedge clock);
      start = 1'b0;
      check("idle_busy", o_busy, 0);
      check("idle_valid", o_valid, 0);
      check("idle_done", o_done, 0);
      check("frame_count", o_count, exp_count);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat[9];
      bit ab;
      n_cmp = 0; n_bad = 0;
      sel = 2'd0; start = 1'b0; char_ready = 1'b1;
      board_a = '0; board_c = '0; board_b = '0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_valid", o_valid, 0);
      check("reset_data", o_data, 8'h00);
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_count", o_count, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // All-empty board at full throughput.
      make_expected(board_a, 3, 3);
      trigger(1'b1);
      capture(0, 0, 0, ab);
      compare_frame();
      compare_literal("\n_ _ _\n_ _ _\n_ _ _\n");
      post_frame(1);

      // Mixed codes including an invalid one; a start during DONE must be ignored.
      pat = '{1, 2, 0, 0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 9; i++) board_a[2*i +: 2] = 2'(pat[i]);
      make_expected(board_a, 3, 3);
      trigger(1'b1);
      capture(0, 0, 0, ab);
      compare_frame();
      compare_literal("\nX O _\n_ X O\n? _ X\n");
      start = 1'b1;
      post_frame(2);

      // Backpressure 1,0,0 with a trigger at the earliest legal cycle.
      board_a = 18'($urandom);
      make_expected(board_a, 3, 3);
      trigger(1'b1);
      capture(1, 0, 0, ab);
      compare_frame();
      post_frame(3);

      // Start and board change mid-frame are ignored and not queued.
      board_a = 18'($urandom);
      make_expected(board_a, 3, 3);
      trigger(1'b1);
      capture(0, 5, 1, ab);
      compare_frame();
      post_frame(4);
      repeat (3) @(negedge clock);
      check("start_not_queued", o_busy, 0);

      for (int f = 0; f < 4; f++) begin
         board_a = 18'($urandom);
         make_expected(board_a, 3, 3);
         trigger(1'b1);
         capture(2, 0, 0, ab);
         compare_frame();
         post_frame(5 + f);
      end

      // Change mode: nothing on an unchanged board, one frame per change.
      sel = 2'd1;
      repeat (5) @(negedge clock);
      check("chg_no_frame_busy", o_busy, 0);
      check("chg_no_frame_valid", o_valid, 0);
      board_c[9:8] = 2'd1;
      make_expected(board_c, 3, 3);
      trigger(1'b0);
      capture(0, 6, 2, ab);
      compare_frame();
      post_frame(1);
      make_expected(board_c, 3, 3);
      trigger(1'b0);
      capture(2, 0, 0, ab);
      compare_frame();
      post_frame(2);
      repeat (5) @(negedge clock);
      check("chg_settled_busy", o_busy, 0);
      check("chg_settled_count", o_count, 2);

      // 2x4 build: 17 characters, then a reset part-way through a frame.
      sel = 2'd2;
      board_b = 16'($urandom);
      make_expected({2'b00, board_b}, 2, 4);
      trigger(1'b1);
      capture(0, 0, 0, ab);
      compare_frame();
      check("b_frame_len17", got_q.size(), 17);
      post_frame(1);
      board_b = 16'($urandom);
      make_expected({2'b00, board_b}, 2, 4);
      trigger(1'b1);
      capture(0, 8, 3, ab);
      check("b_reset_aborted", 32'(ab), 1);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("b_no_done_after_rst", o_done, 0);
      end
      check("b_idle_after_rst", o_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/board_text_stream.md
# board_text_stream

Synthesisable, parametrised board renderer that turns a game-board vector into a byte-wide ASCII character stream. It sits between the board state register and the text sink (UART or simulation console shim) and replaces simulation-only `$write` printing with a valid/ready stream. It generalises to any ROWS×COLS board, configurable cell encoding characters, and an optional print-on-change mode.

## Interface
Parameters:
- ROWS, 3, board rows (≥1)
- COLS, 3, board columns (≥1)
- CELL_W, 2, bits per cell (≥2)
- EMPTY_CHAR, "_", character for cell code 0
- P1_CHAR, "X", character for cell code 1
- P2_CHAR, "O", character for cell code 2
- BAD_CHAR, "?", character for any other cell code
- PRINT_ON_CHANGE, 0, 1 = automatically render when the board differs from the last rendered snapshot

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- board  in  ROWS*COLS*CELL_W  cell i = board[i*CELL_W +: CELL_W], i = r*COLS+c, row-major
- start  in  1  render request, sampled only while idle
- char_data  out  8  ASCII character
- char_valid  out  1  char_data valid
- char_ready  in  1  sink accepts the character
- busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse after the last character is accepted
- frame_count  out  16  completed frames, wraps modulo 2^16

## Operation
- States:
  - IDLE
  - LEAD: emit 0x0A
  - CELL: emit the mapped cell character
  - SEP: emit 0x20
  - EOL: emit 0x0A
  - DONE
- Frame layout: leading "\n", then per row: COLS cell characters separated by single spaces, then "\n". No trailing space.
- Frame length: 1 + ROWS*2*COLS characters; 19 for 3×3.
- Trigger, IDLE only: start=1, or PRINT_ON_CHANGE=1 with board ≠ snapshot.
  - On trigger, snapshot ← board and go to LEAD.
  - The snapshot is the only source for the frame; board changes mid-frame have no effect on it.
- Transitions, each taken only on acceptance (char_valid & char_ready):
  - LEAD→CELL(r=0,c=0).
  - CELL→SEP if c<COLS-1; otherwise EOL.
  - SEP→CELL with c+1.
  - EOL→CELL(r+1,0) if r<ROWS-1; otherwise DONE.
  - DONE→IDLE after one cycle.
- Cell mapping: 0→EMPTY_CHAR, 1→P1_CHAR, 2→P2_CHAR, ≥3→BAD_CHAR.
- start while busy is ignored and is not queued.
- In change mode, a board change during a frame is picked up in IDLE after the frame completes, because the compare is against the snapshot.
- Counters: r is $clog2(ROWS) bits and c is $clog2(COLS) bits (minimum 1 bit each); neither exceeds ROWS-1 / COLS-1. frame_count increments in DONE.

## Timing
- Reset (reset_n=0 at an edge) forces, at that edge:
  - state=IDLE
  - char_valid=0, char_data=0x00
  - busy=0, frame_done=0, frame_count=0
  - snapshot=all zero (all-empty board)
- Reset mid-frame aborts the frame with no frame_done pulse.
- Trigger sampled at edge t: busy=1, char_valid=1, char_data=0x0A from cycle t+1.
- Output stability: char_data and char_valid are registered and held stable while char_valid & !char_ready. The next character is presented the cycle after acceptance.
- Throughput: one character per cycle with char_ready held high. With the last accept at cycle k:
  - frame_done=1, busy=0, char_valid=0 in cycle k+1.
  - IDLE from cycle k+2.
- A trigger is accepted again from cycle k+2. Minimum start-to-start spacing for 3×3 is 21 cycles.
- The trigger is not evaluated while reset_n=0.

## Test plan
- 3×3 all-zero board, start pulse, char_ready=1 → 19 characters "\n_ _ _\n_ _ _\n_ _ _\n" on consecutive cycles; frame_done one cycle after the last accept; frame_count=1.
- board cells = {1,2,0,0,1,2,3,0,1} → "\nX O _\n_ X O\n? _ X\n".
- Backpressure: char_ready toggles 1,0,0,1,… → no character duplicated or skipped; char_data held stable while stalled; frame still 19 characters.
- start pulsed again at character 5, and board changed mid-frame → ignored; output matches the first snapshot; frame_count increments by 1 only.
- PRINT_ON_CHANGE=1 → no frame after reset with an all-zero board; writing cell 4 = 1 triggers exactly one frame; a further change during that frame triggers a second frame after IDLE.
- ROWS=2, COLS=4 build → 17 characters per frame. reset_n=0 at character 8 → char_valid=0, busy=0, frame_count=0 at the next edge, and no frame_done.
